mux4_arbiter: RTL and testbench
===============================

# mux4_arbiter

Round-robin arbiter that shares the single output of a 4-to-1 multiplexer among four requesters. It grants one requester at a time, drives the mux select lines `s1`/`s0` to match the grant, and bounds each grant with a hold quota so no requester can starve the others. It sits directly in front of the mux select inputs in any shared-path datapath.

## Interface

- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may last; legal range 1..255.

- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clock`.
- `req`  in  4  request vector; `req[i]` high means requester i wants the mux output.
- `gnt`  out  4  one-hot (or all-zero) registered grant vector.
- `s1`  out  1  mux select MSB; {s1,s0} equals the index of the granted requester.
- `s0`  out  1  mux select LSB.
- `valid`  out  1  high when `gnt` is non-zero, meaning the mux output belongs to a granted requester.

## Operation

- State machine with two states:
  - IDLE: `gnt`=0 and `valid`=0.
  - GRANT: exactly one `gnt` bit is high and `valid`=1.
- Last-grant pointer `ptr` (2 bits) holds the index of the most recently granted requester.
  - Arbitration priority order is ptr+1, ptr+2, ptr+3, ptr, all modulo 4.
- IDLE -> GRANT when any `req` bit is high.
  - The winner is the first requesting index in priority order.
  - At that edge: `ptr` <= winner, `hold_cnt` <= 1.
- While in GRANT, with owner o:
  - If `req[o]`=1 and `hold_cnt` < MAX_HOLD, keep the grant and increment `hold_cnt`.
  - Otherwise the grant releases at that edge. "Otherwise" means `req[o]`=0, or `hold_cnt`==MAX_HOLD.
- On release:
  - The arbiter re-arbitrates in the same edge, using priority order from `ptr`=o.
  - If any `req` bit is high, the next winner is granted immediately (no idle bubble) and `hold_cnt` <= 1.
  - If no `req` bit is high, the state goes to IDLE.
  - Because o has lowest priority, a quota-expired owner regains the grant only if no other requester is asserting.
- Select outputs:
  - {s1,s0} are registered and update on the same edge as `gnt`, to the winner index.
  - In IDLE, {s1,s0} hold their last value. The mux input therefore stays stable, but it is qualified only by `valid`.
- `hold_cnt` is 8 bits wide. It never exceeds MAX_HOLD and never wraps.
- `req` bits for non-owners are ignored during a grant except at the release edge.

## Timing

- Reset: at the first rising edge with `reset`=1, the block enters:
  - `gnt`=4'b0000, `valid`=0, `s1`=0, `s0`=0.
  - `ptr`=3, so requester 0 has top priority after reset; `hold_cnt`=0; state IDLE.
- Reset takes priority over every other event. Reset asserted mid-grant drops `gnt` and `valid` at that edge.
- Grant latency: `req` sampled high at edge N (from IDLE) gives `gnt` and `valid` high in the cycle after edge N. This is 1-cycle registered latency.
- Release latency: owner drops `req` before edge N, so `gnt[o]` falls at edge N.
  - If another requester is pending, the new `gnt` bit rises at that same edge N.
- Quota: a continuously requesting owner holds `gnt` for exactly MAX_HOLD cycles when others are waiting.
- MAX_HOLD=1: the grant rotates every cycle among all asserting requesters.
- Simultaneous events:
  - Owner drop and quota expiry in the same cycle count as a single release.
  - New requests arriving during the release edge take part in that arbitration.
- `gnt` is never multi-hot, in any cycle.

## Test plan

- Reset, then `req`=4'b1111 held (MAX_HOLD=8) -> `gnt` is 0001 for 8 cycles, then 0010, 0100, 1000 for 8 cycles each, then back to 0001. {s1,s0} tracks 0,1,2,3 and `valid` stays 1 throughout.
- `req`=4'b0100 pulse lasting 3 cycles from IDLE -> `gnt`=0100, {s1,s0}=2'b10 one cycle after the first sample; `gnt` returns to 0 one cycle after `req` falls; `valid` is high for 3 cycles.
- Only `req[1]` held high for 20 cycles (MAX_HOLD=8) -> `gnt` stays 0010 continuously, re-granted at each quota expiry with no bubble.
- Owner 0 granted, `req[0]` drops on the same edge that `req[3]` rises -> `gnt` goes 0001 -> 1000 with no zero cycle.
- MAX_HOLD=1 with `req`=4'b1010 -> `gnt` alternates 0010, 1000 every cycle.
- `reset` asserted for 1 cycle while `gnt`=0100 -> next cycle has `gnt`=0, `valid`=0, {s1,s0}=00. With `req`=1111 after reset, the first grant is 0001.

Source files
------------

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4-to-1 mux.
// Each grant is bounded by a MAX_HOLD cycle quota so no requester can starve the others.
//
// state | meaning
// IDLE  | no requester owns the mux, gnt=0, valid=0, select lines hold last value
// GRANT | requester ptr_q owns the mux, hold_cnt_q counts cycles of this grant
module mux4_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;

    logic       win_found;
    logic [1:0] win_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd3;
            hold_cnt_q <= 8'd0;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
        end
    end

    // Scan from ptr+1 round to ptr itself, so the last owner has lowest priority.
    always_comb begin
        logic [1:0] cand;
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + k[1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = GRANT;
                    ptr_d      = win_idx;
                    hold_cnt_d = 8'd1;
                    gnt_d      = 4'b0001 << win_idx;
                    sel_d      = win_idx;
                end
            end
            GRANT: begin
                if (req[ptr_q] && (hold_cnt_q < MAX_HOLD_C)) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else if (win_found) begin
                    ptr_d      = win_idx;
                    hold_cnt_d = 8'd1;
                    gnt_d      = 4'b0001 << win_idx;
                    sel_d      = win_idx;
                end else begin
                    state_d    = IDLE;
                    hold_cnt_d = 8'd0;
                    gnt_d      = 4'b0000;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = 8'd0;
                gnt_d      = 4'b0000;
            end
        endcase
    end

    always_comb begin
        gnt   = gnt_q;
        valid = (state_q == GRANT);
        s1    = sel_q[1];
        s0    = sel_q[0];
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Scoreboard bench for mux4_arbiter: two instances (quota 8 and quota 1) share one
// request stream and are compared each cycle against a queue-fed reference model.
module tb_mux4_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] sel;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;

    logic [3:0] gnt8, gnt1;
    logic       s1_8, s0_8, s1_1, s0_1, valid8, valid1;

    exp_t q8[$];
    exp_t q1[$];

    int errors = 0;
    int checks = 0;

    int m_busy [2];
    int m_owner[2];
    int m_cnt  [2];
    int m_ptr  [2];
    int m_sel  [2];
    int m_quota[2] = '{8, 1};

    always #5 clock = ~clock;

    mux4_arbiter #(.MAX_HOLD(8)) dut8 (
        .clock(clock), .reset(reset), .req(req),
        .gnt(gnt8), .s1(s1_8), .s0(s0_8), .valid(valid8)
    );

    mux4_arbiter #(.MAX_HOLD(1)) dut1 (
        .clock(clock), .reset(reset), .req(req),
        .gnt(gnt1), .s1(s1_1), .s0(s0_1), .valid(valid1)
    );

    // Reference: an owner keeps the mux while it asks and has quota left; otherwise the
    // first requester found walking forward from the last owner takes over.
    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            if (reset) begin
                m_busy[d] = 0;
                m_ptr[d]  = 3;
                m_cnt[d]  = 0;
                m_sel[d]  = 0;
            end else if (m_busy[d] != 0 && req[m_owner[d]] && m_cnt[d] < m_quota[d]) begin
                m_cnt[d] = m_cnt[d] + 1;
            end else begin
                int winner;
                winner = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (winner < 0 && req[(m_ptr[d] + k) % 4]) winner = (m_ptr[d] + k) % 4;
                end
                if (winner >= 0) begin
                    m_busy[d]  = 1;
                    m_owner[d] = winner;
                    m_ptr[d]   = winner;
                    m_cnt[d]   = 1;
                    m_sel[d]   = winner;
                end else begin
                    m_busy[d] = 0;
                    m_cnt[d]  = 0;
                end
            end
            e.gnt   = (m_busy[d] != 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
            e.valid = (m_busy[d] != 0);
            e.sel   = 2'(m_sel[d]);
            if (d == 0) q8.push_back(e);
            else        q1.push_back(e);
        end
    end

    task automatic compare(input string name, input exp_t e,
                           input logic [3:0] g, input logic v, input logic [1:0] s);
        checks++;
        if (g !== e.gnt || v !== e.valid || s !== e.sel) begin
            errors++;
            $display("FAIL %s t=%0t: got gnt=%b valid=%b sel=%0d, expected gnt=%b valid=%b sel=%0d",
                     name, $time, g, v, s, e.gnt, e.valid, e.sel);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q8.size() == 0 || q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty t=%0t: got q8=%0d q1=%0d entries, expected at least 1",
                     $time, q8.size(), q1.size());
        end else begin
            e = q8.pop_front();
            compare("quota8", e, gnt8, valid8, {s1_8, s0_8});
            e = q1.pop_front();
            compare("quota1", e, gnt1, valid1, {s1_1, s0_1});
            checks++;
            if ($countones(gnt8) > 1 || $countones(gnt1) > 1) begin
                errors++;
                $display("FAIL onehot t=%0t: got gnt8=%b gnt1=%b, expected at most one bit",
                         $time, gnt8, gnt1);
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic rst, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            req   = r;
            reset = rst;
        end
    endtask

    initial begin
        drive(4'b0000, 1'b1, 2);
        drive(4'b1111, 1'b0, 40);   // full rotation with quota 8
        drive(4'b0000, 1'b0, 3);
        drive(4'b0100, 1'b0, 3);    // short pulse from idle
        drive(4'b0000, 1'b0, 3);
        drive(4'b0010, 1'b0, 20);   // lone requester re-granted at quota expiry
        drive(4'b0000, 1'b0, 2);
        drive(4'b0001, 1'b0, 3);
        drive(4'b1000, 1'b0, 4);    // owner drops while another rises, same edge
        drive(4'b0000, 1'b0, 2);
        drive(4'b1010, 1'b0, 10);   // quota-1 instance alternates
        drive(4'b0000, 1'b0, 2);
        drive(4'b0100, 1'b0, 2);
        drive(4'b0100, 1'b1, 1);    // reset mid-grant
        drive(4'b1111, 1'b0, 5);
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            logic       rst;
            r   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : req;
            rst = ($urandom_range(0, 59) == 0);
            drive(r, rst, 1);
        end
        drive(4'b0000, 1'b0, 3);
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
